// File: rtl/commit_unit.sv
// ROB commit consumer: retires in-order entries into the register file, releases
// committed stores to the store buffer, latches halt and counts retirements.
package commit_pkg;
    localparam int INSTR_W      = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int DATA_W       = 32;
    localparam int RSV_ID_W     = 4;
    localparam int STATION_ID_W = 6;

    typedef struct packed {
        logic [INSTR_W-1:0]      opcode;
        logic [REG_ADDR_W-1:0]   dst_reg;
        logic [DATA_W-1:0]       content;
        logic [STATION_ID_W-1:0] station_id;
    } station_t;
endpackage

module commit_unit
    import commit_pkg::*;
#(
    parameter int             OP_W     = 6,
    parameter logic [OP_W-1:0] OP_STORE = 6'h2b,
    parameter logic [OP_W-1:0] OP_HALT  = 6'h3f,
    parameter int             CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_valid,
    input  station_t              i_commit_data,
    output logic                  i_ready,
    input  logic                  clear,
    output logic                  reg_we,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0]     reg_data,
    output logic [RSV_ID_W-1:0]   reg_rsv_id,
    output logic                  st_commit_valid,
    input  logic                  st_commit_ready,
    output logic                  o_halted,
    output logic [CNT_W-1:0]      o_retired
);
    typedef enum logic [1:0] {RUN, STORE_WAIT, HALTED} state_t;

    state_t          state;
    logic [OP_W-1:0] major;
    logic            accept;
    logic            is_store;
    logic            is_halt;
    logic            unused_bits;

    assign major    = i_commit_data.opcode[INSTR_W-1 -: OP_W];
    assign is_store = (major == OP_STORE);
    assign is_halt  = (major == OP_HALT);
    assign i_ready  = (state == RUN) && !clear && !nrst;
    assign accept   = i_valid && i_ready;

    assign unused_bits = ^{i_commit_data.opcode[INSTR_W-OP_W-1:0],
                           i_commit_data.station_id[STATION_ID_W-1:RSV_ID_W]};

    always_ff @(posedge clk) begin
        if (nrst) begin
            state           <= RUN;
            reg_we          <= 1'b0;
            reg_addr        <= '0;
            reg_data        <= '0;
            reg_rsv_id      <= '0;
            st_commit_valid <= 1'b0;
            o_halted        <= 1'b0;
            o_retired       <= '0;
        end else begin
            // Write strobe lasts exactly one cycle per accepted REG entry.
            reg_we <= 1'b0;
            if (accept)
                o_retired <= o_retired + CNT_W'(1);
            case (state)
                RUN: begin
                    if (accept) begin
                        if (is_store) begin
                            state           <= STORE_WAIT;
                            st_commit_valid <= 1'b1;
                        end else if (is_halt) begin
                            state    <= HALTED;
                            o_halted <= 1'b1;
                        end else if (i_commit_data.dst_reg != '0) begin
                            reg_we     <= 1'b1;
                            reg_addr   <= i_commit_data.dst_reg;
                            reg_data   <= i_commit_data.content;
                            reg_rsv_id <= i_commit_data.station_id[RSV_ID_W-1:0];
                        end
                    end
                end
                // Store is already architectural: clear cannot abort its release.
                STORE_WAIT: begin
                    if (st_commit_valid && st_commit_ready) begin
                        state           <= RUN;
                        st_commit_valid <= 1'b0;
                    end
                end
                HALTED: begin
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_commit_unit.sv
// Bench for commit_unit: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model of the commit rules.
module tb_commit_unit;
    import commit_pkg::*;

    localparam logic [5:0] MAJ_STORE = 6'h2b;
    localparam logic [5:0] MAJ_HALT  = 6'h3f;
    localparam logic [5:0] MAJ_ALU   = 6'h08;

    logic            clk = 1'b0;
    logic            nrst = 1'b1;
    logic            i_valid = 1'b0;
    station_t        i_commit_data = '0;
    logic            i_ready;
    logic            clear = 1'b0;
    logic            reg_we;
    logic [4:0]      reg_addr;
    logic [31:0]     reg_data;
    logic [3:0]      reg_rsv_id;
    logic            st_commit_valid;
    logic            st_commit_ready = 1'b0;
    logic            o_halted;
    logic [31:0]     o_retired;

    int checks = 0;
    int errors = 0;

    commit_unit dut (
        .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_commit_data(i_commit_data),
        .i_ready(i_ready), .clear(clear), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_data(reg_data), .reg_rsv_id(reg_rsv_id), .st_commit_valid(st_commit_valid),
        .st_commit_ready(st_commit_ready), .o_halted(o_halted), .o_retired(o_retired)
    );

    always #5 clk = ~clk;

    // Behavioural model: a pending-store flag, a halted flag, a counter and the
    // write expected to be visible in the current cycle.
    logic        m_halted = 1'b0;
    logic        m_pend   = 1'b0;
    logic [31:0] m_retired = '0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_rsv  = '0;

    wire [5:0] m_major = i_commit_data.opcode[31:26];
    wire       m_ready = !m_halted && !m_pend && !clear && !nrst;
    wire       m_acc   = i_valid && m_ready;

    always @(posedge clk) begin
        if (nrst) begin
            m_halted  <= 1'b0;
            m_pend    <= 1'b0;
            m_retired <= '0;
            m_we      <= 1'b0;
        end else begin
            m_we <= 1'b0;
            if (m_pend && st_commit_ready)
                m_pend <= 1'b0;
            if (m_acc) begin
                m_retired <= m_retired + 32'd1;
                if (m_major == MAJ_STORE)
                    m_pend <= 1'b1;
                else if (m_major == MAJ_HALT)
                    m_halted <= 1'b1;
                else if (i_commit_data.dst_reg != 0) begin
                    m_we   <= 1'b1;
                    m_addr <= i_commit_data.dst_reg;
                    m_data <= i_commit_data.content;
                    m_rsv  <= 4'(i_commit_data.station_id % 16);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        chk("model.i_ready", 64'(i_ready), 64'(m_ready));
        chk("model.reg_we", 64'(reg_we), 64'(m_we));
        if (m_we) begin
            chk("model.reg_addr", 64'(reg_addr), 64'(m_addr));
            chk("model.reg_data", 64'(reg_data), 64'(m_data));
            chk("model.reg_rsv_id", 64'(reg_rsv_id), 64'(m_rsv));
        end
        chk("model.st_commit_valid", 64'(st_commit_valid), 64'(m_pend));
        chk("model.o_halted", 64'(o_halted), 64'(m_halted));
        chk("model.o_retired", 64'(o_retired), 64'(m_retired));
    end

    function automatic station_t mk(input logic [5:0] maj, input int dst, input int data, input int id);
        station_t e;
        logic [31:0] op;
        op        = $urandom;
        op[31:26] = maj;
        e.opcode     = op;
        e.dst_reg    = 5'(dst);
        e.content    = 32'(data);
        e.station_id = 6'(id);
        return e;
    endfunction

    task automatic drive(input logic v, input station_t e, input logic clr, input logic rst, input logic ack);
        @(negedge clk);
        i_valid = v; i_commit_data = e; clear = clr; nrst = rst; st_commit_ready = ack;
        #2;
    endtask

    station_t idle;
    station_t r9;

    initial begin
        idle = mk(MAJ_ALU, 0, 0, 0);
        r9   = mk(MAJ_ALU, 9, 32'h99, 7);

        // Reset state
        drive(0, idle, 0, 1, 0);
        chk("rst.i_ready", 64'(i_ready), 64'd0);
        drive(0, idle, 0, 0, 0);
        chk("rst.retired", 64'(o_retired), 64'd0);
        chk("rst.halted", 64'(o_halted), 64'd0);
        chk("rst.stv", 64'(st_commit_valid), 64'd0);
        chk("rst.reg_we", 64'(reg_we), 64'd0);
        chk("rst.reg_addr", 64'(reg_addr), 64'd0);
        chk("rst.reg_data", 64'(reg_data), 64'd0);

        // Back-to-back REG commits
        drive(1, mk(MAJ_ALU, 5, 32'h11, 2), 0, 0, 0);
        chk("b2b.ready0", 64'(i_ready), 64'd1);
        drive(1, mk(MAJ_ALU, 6, 32'h22, 3), 0, 0, 0);
        chk("b2b.ready1", 64'(i_ready), 64'd1);
        chk("b2b.we0", 64'(reg_we), 64'd1);
        chk("b2b.addr0", 64'(reg_addr), 64'd5);
        chk("b2b.data0", 64'(reg_data), 64'h11);
        chk("b2b.rsv0", 64'(reg_rsv_id), 64'd2);
        drive(1, mk(MAJ_ALU, 7, 32'h33, 4), 0, 0, 0);
        chk("b2b.we1", 64'(reg_we), 64'd1);
        chk("b2b.data1", 64'(reg_data), 64'h22);
        chk("b2b.rsv1", 64'(reg_rsv_id), 64'd3);
        drive(0, idle, 0, 0, 0);
        chk("b2b.we2", 64'(reg_we), 64'd1);
        chk("b2b.addr2", 64'(reg_addr), 64'd7);
        chk("b2b.data2", 64'(reg_data), 64'h33);
        chk("b2b.rsv2", 64'(reg_rsv_id), 64'd4);
        chk("b2b.retired", 64'(o_retired), 64'd3);
        drive(0, idle, 0, 0, 0);
        chk("b2b.we_off", 64'(reg_we), 64'd0);

        // Write to register 0
        drive(1, mk(MAJ_ALU, 0, 32'haa, 5), 0, 0, 0);
        chk("r0.ready", 64'(i_ready), 64'd1);
        drive(0, idle, 0, 0, 0);
        chk("r0.we", 64'(reg_we), 64'd0);
        chk("r0.retired", 64'(o_retired), 64'd4);

        // Store handshake, with clear raised mid-wait
        drive(1, mk(MAJ_STORE, 3, 32'h5, 1), 0, 0, 0);
        chk("st.ready", 64'(i_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            drive(1, r9, k == 2, 0, 0);
            chk("st.stv_wait", 64'(st_commit_valid), 64'd1);
            chk("st.ready_wait", 64'(i_ready), 64'd0);
            chk("st.we_wait", 64'(reg_we), 64'd0);
        end
        drive(1, r9, 0, 0, 1);
        chk("st.stv_ack", 64'(st_commit_valid), 64'd1);
        chk("st.ready_ack", 64'(i_ready), 64'd0);
        drive(1, r9, 0, 0, 1);
        chk("st.stv_done", 64'(st_commit_valid), 64'd0);
        chk("st.ready_after", 64'(i_ready), 64'd1);
        chk("st.retired", 64'(o_retired), 64'd5);
        drive(0, idle, 0, 0, 0);
        chk("st.we_after", 64'(reg_we), 64'd1);
        chk("st.addr_after", 64'(reg_addr), 64'd9);
        chk("st.data_after", 64'(reg_data), 64'h99);
        chk("st.retired2", 64'(o_retired), 64'd6);

        // Clear together with valid
        drive(1, mk(MAJ_ALU, 3, 32'h77, 6), 1, 0, 0);
        chk("clr.ready", 64'(i_ready), 64'd0);
        drive(0, idle, 0, 0, 0);
        chk("clr.retired", 64'(o_retired), 64'd6);
        chk("clr.we", 64'(reg_we), 64'd0);

        // Halt
        drive(1, mk(MAJ_HALT, 0, 0, 8), 0, 0, 0);
        chk("halt.ready", 64'(i_ready), 64'd1);
        drive(1, r9, 0, 0, 1);
        chk("halt.halted", 64'(o_halted), 64'd1);
        chk("halt.ready_off", 64'(i_ready), 64'd0);
        chk("halt.retired", 64'(o_retired), 64'd7);
        drive(1, r9, 1, 0, 0);
        drive(1, r9, 0, 0, 0);
        chk("halt.ready_off2", 64'(i_ready), 64'd0);
        chk("halt.retired2", 64'(o_retired), 64'd7);
        drive(0, idle, 0, 1, 0);
        drive(0, idle, 0, 0, 0);
        chk("halt.rst_halted", 64'(o_halted), 64'd0);
        chk("halt.rst_retired", 64'(o_retired), 64'd0);

        // Reset mid-operation: REG write visible while store is accepted, then reset in wait
        drive(1, mk(MAJ_ALU, 4, 32'h44, 1), 0, 0, 0);
        drive(1, mk(MAJ_STORE, 1, 32'h1, 2), 0, 0, 0);
        chk("mid.we", 64'(reg_we), 64'd1);
        drive(0, idle, 0, 1, 0);
        chk("mid.stv_pre", 64'(st_commit_valid), 64'd1);
        chk("mid.ready_rst", 64'(i_ready), 64'd0);
        drive(1, mk(MAJ_ALU, 2, 32'h55, 9), 0, 0, 0);
        chk("mid.stv", 64'(st_commit_valid), 64'd0);
        chk("mid.we0", 64'(reg_we), 64'd0);
        chk("mid.addr0", 64'(reg_addr), 64'd0);
        chk("mid.data0", 64'(reg_data), 64'd0);
        chk("mid.rsv0", 64'(reg_rsv_id), 64'd0);
        chk("mid.retired0", 64'(o_retired), 64'd0);
        chk("mid.ready", 64'(i_ready), 64'd1);
        drive(0, idle, 0, 0, 0);
        chk("mid.we1", 64'(reg_we), 64'd1);
        chk("mid.addr1", 64'(reg_addr), 64'd2);
        chk("mid.rsv1", 64'(reg_rsv_id), 64'd9);
        chk("mid.retired1", 64'(o_retired), 64'd1);

        // Random traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] maj;
            int sel;
            sel = $urandom_range(0, 99);
            maj = (sel < 15) ? MAJ_STORE : (sel < 18) ? MAJ_HALT : 6'($urandom_range(0, 42));
            drive($urandom_range(0, 9) < 7,
                  mk(maj, $urandom_range(0, 31), $urandom, $urandom_range(0, 63)),
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) < 4);
        end

        drive(0, idle, 0, 0, 0);
        drive(0, idle, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- Consumer end of the reorder-buffer commit interface: takes in-order retiring entries (station_t) and makes them architecturally visible.
- Writes results to the register file and releases the rename tag held by the destination register.
- Releases committed stores to the store buffer and waits for its acknowledgement.
- Latches halt, and counts retired instructions.

Parameters:
- OP_W, 6, width of opcode major field (opcode[INSTR_W-1 -: OP_W]) used for classification
- OP_STORE, 6'h2b, major opcode value classified as store
- OP_HALT, 6'h3f, major opcode value classified as halt
- CNT_W, 32, width of retire counter

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous reset, active-high (nrst=1 resets on the next rising edge)
- i_valid  in  1  ROB head entry valid and ready (ROB o_valid)
- i_commit_data  in  station_t  ROB head entry (ROB o_commit_data)
- i_ready  out  1  commit accepted this cycle (drives ROB o_ready)
- clear  in  1  flush from branch unit
- reg_we  out  1  register file write strobe
- reg_addr  out  REG_ADDR_W  destination register
- reg_data  out  DATA_W  write data
- reg_rsv_id  out  RSV_ID_W  ROB tag; register file frees rename only if tag matches
- st_commit_valid  out  1  release oldest store in store buffer
- st_commit_ready  in  1  store buffer accepted release
- o_halted  out  1  halt retired
- o_retired  out  CNT_W  retired-instruction count

Behaviour:
- Classification of an accepted entry, by major opcode:
  - STORE: major == OP_STORE.
  - HALT: major == OP_HALT.
  - otherwise REG; a REG entry writes only if dst_reg != 0.
- Accept condition: i_valid && i_ready.
  - i_ready = (state==RUN) && !clear && !nrst. Combinational.
  - i_ready does not depend on i_valid.
- States:
  - RUN:
    - REG accept → stay RUN.
    - STORE accept → STORE_WAIT.
    - HALT accept → HALTED.
  - STORE_WAIT:
    - st_commit_valid=1.
    - Leave to RUN in the cycle after the edge where st_commit_valid && st_commit_ready.
    - i_ready=0 throughout.
  - HALTED:
    - Terminal; i_ready=0, o_halted=1.
    - Only reset exits.
- Register write (REG accept at edge N, dst_reg != 0):
  - reg_we=1 for exactly the cycle after edge N.
  - reg_addr=dst_reg.
  - reg_data=content.
  - reg_rsv_id=station_id[RSV_ID_W-1:0].
  - All outputs are registered.
  - Back-to-back REG accepts produce back-to-back single-cycle writes; throughput is 1 per cycle.
- Store release:
  - st_commit_valid rises the cycle after the STORE accept edge.
  - Held until handshake, then deasserts.
  - A STORE never asserts reg_we.
- o_retired:
  - +1 at every accept edge, for all classes.
  - Wraps modulo 2^CNT_W.
- Clear:
  - Blocks acceptance in its cycle.
  - Does not cancel an already-registered reg write.
  - Does not abort STORE_WAIT: the store is already architectural, so its release completes.
  - Has no effect in HALTED.
- Simultaneous cases:
  - clear with i_valid → no accept, no count.
  - st_commit_ready high outside STORE_WAIT → ignored.
- Reset (any state, including mid-STORE_WAIT) on the next edge:
  - state=RUN.
  - reg_we=0, reg_addr=0, reg_data=0, reg_rsv_id=0.
  - st_commit_valid=0.
  - o_halted=0.
  - o_retired=0.
  - A pending store release is dropped; the store buffer is reset by the same reset.
- i_ready is 0 while nrst=1.

Test Plan:
- Back-to-back REG commits:
  - Stimulus: reset, then i_valid=1 for 3 cycles with dst_reg=5/6/7, content=0x11/0x22/0x33, station_id=2/3/4.
  - Required: i_ready=1 each cycle; reg_we high 3 consecutive cycles with matching addr/data/rsv_id, one cycle after each accept; o_retired=3.
- Write to register 0:
  - Stimulus: REG commit with dst_reg=0.
  - Required: accepted; reg_we stays 0; o_retired increments by 1.
- Store handshake:
  - Stimulus: STORE commit; hold st_commit_ready=0 for 4 cycles, then 1.
  - Required: st_commit_valid high 5 cycles; i_ready=0 throughout; i_valid held on a REG entry is accepted the cycle after release; no reg_we for the store.
- Clear interactions:
  - Stimulus: clear=1 together with i_valid=1.
  - Required: i_ready=0, no accept, no count.
  - Stimulus: clear=1 during STORE_WAIT.
  - Required: st_commit_valid stays asserted until ready.
- Halt:
  - Stimulus: HALT commit, then further i_valid.
  - Required: o_halted=1 from the next cycle; i_ready=0 forever; o_retired counts the halt only; reset clears o_halted.
- Reset mid-operation:
  - Stimulus: nrst=1 during STORE_WAIT with a reg write pending.
  - Required: all outputs 0 after the edge; state RUN; next commit accepted normally.
